rom_burst_reader: RTL and testbench

Upstream sequencer for the team's synchronous 1-read-port ROM (1-cycle read latency, read gated by enable). On a start command it issues a burst of consecutive ROM reads and returns the words as a valid/ready stream. A 2-entry buffer and a credit rule absorb downstream backpressure: no word is lost or duplicated, and throughput is one word per cycle when the consumer is ready.

---
 rtl/rom_burst_reader.sv | 155 +++++++++++++++
 tb/tb_rom_burst_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: sequences a burst of consecutive reads from a 1-cycle-latency
// synchronous ROM and returns the words as a valid/ready stream. A 2-entry buffer
// and a credit rule keep backpressure from ever losing or duplicating a word.
module rom_burst_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_issueCnt;
    logic [ADDR_WIDTH:0]   r_beatCnt;
    logic                  r_pending;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_level;
    logic [2:0]            w_afterPop;
    logic                  w_issue;

    // A word leaves when the consumer takes the head; a word arrives the cycle after a read.
    assign w_pop      = m_valid & m_ready;
    assign w_push     = r_pending;

    // Words already owed to the buffer (stored plus in flight) minus the one leaving now
    // must stay below 2, otherwise the word returned next cycle would have nowhere to go.
    assign w_level    = {1'b0, r_occ} + {2'b00, r_pending};
    assign w_afterPop = w_level - {2'b00, w_pop};
    assign w_issue    = (r_state == S_RUN) && (r_issueCnt != LEN_ZERO) && (w_afterPop < 3'd2);

    assign rom_en     = w_issue;
    assign rom_addr   = r_addr;

    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf0;
    assign m_last     = m_valid && (r_beatCnt == LEN_ONE);

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    // Burst control: state, read address, issue and beat counters, in-flight flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_issueCnt <= '0;
            r_beatCnt  <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_pending <= w_issue;
            if (w_pop) begin
                r_beatCnt <= r_beatCnt - LEN_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length != LEN_ZERO) begin
                            r_addr     <= start_addr;
                            r_issueCnt <= length;
                            r_beatCnt  <= length;
                            r_state    <= S_RUN;
                        end else begin
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_addr     <= r_addr + ADDR_ONE;
                        r_issueCnt <= r_issueCnt - LEN_ONE;
                        if (r_issueCnt == LEN_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && m_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry FIFO: entry 0 is the stream head, entry 1 holds a word parked behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= rom_dout;
                    end else begin
                        r_buf1 <= rom_dout;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= rom_dout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= rom_dout;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed bursts against a behavioural ROM; expected beats are
// queued at burst start and a negedge monitor pops and compares every transfer.
module tb_rom_burst_reader;

    localparam int DW = 4;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    logic [DW-1:0] romMem [16];
    logic [DW:0]   sbQueue [$];

    int checkCount = 0;
    int passCount  = 0;
    int beatCount  = 0;
    int outstanding = 0;
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevData  = '0;

    rom_burst_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents and the ROM's own registered read port.
    initial begin
        romMem[0]  = 4'hA; romMem[1]  = 4'h1; romMem[2]  = 4'hC; romMem[3]  = 4'hE;
        romMem[4]  = 4'h0; romMem[5]  = 4'h5; romMem[6]  = 4'h2; romMem[7]  = 4'hF;
        romMem[8]  = 4'h7; romMem[9]  = 4'h9; romMem[10] = 4'h3; romMem[11] = 4'hB;
        romMem[12] = 4'h8; romMem[13] = 4'h4; romMem[14] = 4'hD; romMem[15] = 4'h6;
        rom_dout   = '0;
    end

    always @(posedge clk) begin
        if (rom_en) rom_dout <= romMem[rom_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Queues the expected beats, then holds start for exactly one cycle.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW:0] len);
        logic [AW-1:0] idx;
        for (int i = 0; i < int'(len); i++) begin
            idx = addr + AW'(i);
            sbQueue.push_back({(i == int'(len) - 1), romMem[idx]});
        end
        start      = 1'b1;
        start_addr = addr;
        length     = len;
        stepCycle();
        start      = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput({name, "_done_seen"}, done, 1);
        checkOutput({name, "_busy_at_done"}, busy, 1);
        stepCycle();
        checkOutput({name, "_busy_after"}, busy, 0);
        checkOutput({name, "_done_after"}, done, 0);
        checkOutput({name, "_queue_empty"}, sbQueue.size(), 0);
    endtask

    // Monitor: scoreboard pop on every transfer, stall stability, read-credit bound.
    always @(negedge clk) begin
        logic [DW:0] exp;
        logic        pop;
        if (!rst_n) begin
            outstanding = 0;
            prevStall   = 1'b0;
        end else begin
            pop = m_valid && m_ready;
            if (prevStall) begin
                checkOutput("stall_hold_valid", m_valid, 1);
                checkOutput("stall_hold_data", m_data, prevData);
            end
            if (rom_en) checkOutput("occupancy_bound", ((outstanding - int'(pop)) < 2), 1);
            if (pop) begin
                checkOutput("beat_expected", (sbQueue.size() != 0), 1);
                if (sbQueue.size() != 0) begin
                    exp = sbQueue.pop_front();
                    checkOutput("beat_data", m_data, exp[DW-1:0]);
                    checkOutput("beat_last", m_last, exp[DW]);
                end
                beatCount++;
            end
            outstanding = outstanding + int'(rom_en) - int'(pop);
            prevStall   = m_valid && !m_ready;
            prevData    = m_data;
        end
    end

    // Watchdog so a stuck design still yields a summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        checkCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", m_valid, 0);
        checkOutput("rst_last", m_last, 0);
        checkOutput("rst_data", m_data, 0);
        checkOutput("rst_rom_en", rom_en, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);
        rst_n = 1'b1;
        stepCycle();

        $display("[TB] test 1: basic burst");
        applyStimulus(4'd2, 5'd4);
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4) begin
                checkOutput("t1_rom_en", rom_en, 1);
                checkOutput("t1_rom_addr", rom_addr, 1 + c);
            end
            if (c == 2) checkOutput("t1_valid_c2", m_valid, 0);
            if (c == 3) checkOutput("t1_valid_c3", m_valid, 1);
            if (c == 5) checkOutput("t1_rom_en_c5", rom_en, 0);
            if (c == 6) checkOutput("t1_last_c6", m_last, 1);
            if (c == 7) begin
                checkOutput("t1_done_c7", done, 1);
                checkOutput("t1_busy_c7", busy, 1);
            end
            if (c == 8) begin
                checkOutput("t1_busy_c8", busy, 0);
                checkOutput("t1_done_c8", done, 0);
            end
            if (c < 8) stepCycle();
        end
        checkOutput("t1_queue_empty", sbQueue.size(), 0);

        $display("[TB] test 2: wrap-around");
        applyStimulus(4'd14, 5'd4);
        for (int c = 1; c <= 4; c++) begin
            checkOutput("t2_rom_addr", rom_addr, (13 + c) % 16);
            stepCycle();
        end
        waitDone("t2", 20);

        $display("[TB] test 3: backpressure");
        applyStimulus(4'd0, 5'd8);
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) m_ready = 1'b0;
            stepCycle();
        end
        m_ready = 1'b1;
        waitDone("t3", 30);

        $display("[TB] test 4: zero length");
        applyStimulus(4'd3, 5'd0);
        checkOutput("t4_done_c1", done, 1);
        checkOutput("t4_busy_c1", busy, 1);
        checkOutput("t4_rom_en_c1", rom_en, 0);
        checkOutput("t4_valid_c1", m_valid, 0);
        stepCycle();
        checkOutput("t4_done_c2", done, 0);
        checkOutput("t4_busy_c2", busy, 0);
        checkOutput("t4_rom_en_c2", rom_en, 0);
        checkOutput("t4_valid_c2", m_valid, 0);

        $display("[TB] test 5: full space with ignored start");
        beatCount = 0;
        applyStimulus(4'd0, 5'd16);
        for (int c = 1; c < 5; c++) stepCycle();
        start = 1'b1; start_addr = 4'd9; length = 5'd3;
        stepCycle();
        start = 1'b0;
        waitDone("t5", 60);
        checkOutput("t5_beats", beatCount, 16);

        $display("[TB] test 6: reset mid-burst");
        beatCount = 0;
        applyStimulus(4'd0, 5'd8);
        for (int n = 0; n < 30 && beatCount < 2; n++) stepCycle();
        checkOutput("t6_two_beats", beatCount, 2);
        rst_n = 1'b0;
        stepCycle();
        sbQueue.delete();
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_valid", m_valid, 0);
        checkOutput("t6_last", m_last, 0);
        checkOutput("t6_data", m_data, 0);
        checkOutput("t6_rom_en", rom_en, 0);
        checkOutput("t6_rom_addr", rom_addr, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput("t6_no_done", done, 0);
            checkOutput("t6_idle", busy, 0);
        end
        beatCount = 0;
        applyStimulus(4'd5, 5'd2);
        waitDone("t6b", 20);
        checkOutput("t6b_beats", beatCount, 2);

        stepCycle();
        stepCycle();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
